// File: rtl/core_ctrl_pkg.sv
// +------------------------------------------------------------------+
// | core_ctrl_pkg                                                     |
// | Shared types and encodings for the multi-cycle RV64 control path. |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package core_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADDR = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWR   = 4'd5,
    S_WB_MEM  = 4'd6,
    S_EXEC_R  = 4'd7,
    S_WB_ALU  = 4'd8,
    S_BRANCH  = 4'd9
  } state_t;

  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_SD    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic       SRCA_PC   = 1'b0;
  localparam logic       SRCA_RS1  = 1'b1;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       aluout_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       instr_done;
  } ctrl_t;

  // States that stall on the memory port and are covered by the timeout
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_out_decode.sv
// +------------------------------------------------------------------+
// | ctrl_out_decode                                                   |
// | Combinational state-to-control-vector table for multicycle_ctrl.  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module ctrl_out_decode
  import core_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   zero,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a    = SRCA_PC;
        ctrl.alu_src_b    = SRCB_IMM;
        ctrl.alu_op       = ALUOP_ADD;
        ctrl.aluout_write = 1'b1;
      end
      S_MEMADDR: begin
        ctrl.alu_src_a    = SRCA_RS1;
        ctrl.alu_src_b    = SRCB_IMM;
        ctrl.alu_op       = ALUOP_ADD;
        ctrl.aluout_write = 1'b1;
      end
      S_MEMRD: ctrl.mem_read = 1'b1;
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a    = SRCA_RS1;
        ctrl.alu_src_b    = SRCB_RS2;
        ctrl.alu_op       = ALUOP_FUNCT;
        ctrl.aluout_write = 1'b1;
      end
      S_WB_ALU: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      // Only output that depends on a datapath flag: branch taken on zero
      S_BRANCH: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.pc_src     = 1'b1;
        ctrl.pc_write   = zero;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// +------------------------------------------------------------------+
// | multicycle_ctrl                                                   |
// | Main control FSM of the multi-cycle RV64 core, with memory        |
// | timeout trap. Optional perf counters under macro PERF_CNT_EN.     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module multicycle_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       aluout_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state_dbg
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  localparam int          c_to_w    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(MEM_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [c_to_w-1:0] r_to_cnt;
  logic              r_illegal;
  logic              r_bus_err;
  logic              w_wait;
  logic              w_timeout;
  logic              w_set_illegal;
  ctrl_t             w_ctrl;

  assign w_wait    = is_wait_state(r_state) && !mem_ready;
  assign w_timeout = w_wait && (r_to_cnt == c_to_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_to_cnt  <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_to_cnt  <= (w_wait && !w_timeout) ? r_to_cnt + 1'b1 : '0;
      r_illegal <= r_illegal | w_set_illegal;
      r_bus_err <= r_bus_err | w_timeout;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH: begin
        if (mem_ready)      w_next = S_DECODE;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LD, OP_SD: w_next = S_MEMADDR;
          OP_RTYPE:     w_next = S_EXEC_R;
          OP_BEQ:       w_next = S_BRANCH;
          default: begin
            w_next        = S_FETCH;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADDR: w_next = (opcode == OP_SD) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready)      w_next = S_WB_MEM;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_MEMWR: begin
        if (mem_ready)      w_next = S_FETCH;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_EXEC_R: w_next = S_WB_ALU;
      S_WB_MEM, S_WB_ALU, S_BRANCH: w_next = S_FETCH;
      default:  w_next = S_IDLE;
    endcase
  end

  ctrl_out_decode u_decode (
    .state     (r_state),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (w_ctrl)
  );

  assign alu_op       = w_ctrl.alu_op;
  assign alu_src_a    = w_ctrl.alu_src_a;
  assign alu_src_b    = w_ctrl.alu_src_b;
  assign mem_read     = w_ctrl.mem_read;
  assign mem_write    = w_ctrl.mem_write;
  assign ir_write     = w_ctrl.ir_write;
  assign pc_write     = w_ctrl.pc_write;
  assign pc_src       = w_ctrl.pc_src;
  assign aluout_write = w_ctrl.aluout_write;
  assign reg_write    = w_ctrl.reg_write;
  assign mem_to_reg   = w_ctrl.mem_to_reg;
  assign instr_done   = w_ctrl.instr_done;
  assign illegal      = r_illegal;
  assign bus_err      = r_bus_err;
  assign state_dbg    = r_state;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (r_state != S_IDLE)  r_cycle_cnt   <= r_cycle_cnt + 1'b1;
      if (w_ctrl.instr_done)  r_instret_cnt <= r_instret_cnt + 1'b1;
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`endif

endmodule

`default_nettype wire
